qc_ldpc_encoder_sraa_param: RTL
===============================

QC_LDPC_ENCODER_SRAA_PARAM -- requirements
Module: qc_ldpc_encoder_sraa_param

Interface
REQ-001 SHALL have parameter CIRC_SIZE, default 88, circulant size b in bits.
REQ-002 SHALL have parameter NUM_PAR_BLOCKS, default 16, parity circulant count c (SRAA channels).
REQ-003 SHALL have parameter NUM_INFO_BLOCKS, default 32, info block count t; G row-block memory depth.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  begin a codeword; sampled only in IDLE.
REQ-008 info_bit  input  1  serial information bit.
REQ-009 info_valid  input  1  info_bit is valid this cycle.
REQ-010 info_ready  output  1  high only in ACCUM; a bit transfers when info_valid and info_ready are both high.
REQ-011 g_addr  output  max(1,clog2(NUM_INFO_BLOCKS))  G memory row-block address.
REQ-012 g_data  input  CIRC_SIZE*NUM_PAR_BLOCKS  first generator row of block g_addr; valid exactly one cycle after g_addr is driven; segment j = bits [(j+1)*b-1 : j*b].
REQ-013 parity  output  CIRC_SIZE*NUM_PAR_BLOCKS  accumulated parity vector.
REQ-014 parity_valid  output  1  parity is final.
REQ-015 parity_ready  input  1  consumer accepts parity.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, LOAD, ACCUM, DONE.
REQ-018 IDLE with start=1 SHALL clear the accumulator and block counter and go to FETCH; with start=0 it SHALL stay in IDLE and parity SHALL hold its last value.
REQ-019 FETCH SHALL drive g_addr = block counter and go to LOAD unconditionally.
REQ-020 LOAD SHALL capture g_data into the shift register, clear the bit counter and go to ACCUM.
REQ-021 ACCUM, on each transferred bit: accumulator ^= (info_bit ? shift register : 0), using the pre-rotation value; every segment then rotates so that new_seg[k] = seg[(k-1) mod b]; bit counter increments.
REQ-022 With info_valid=0 in ACCUM, all state SHALL hold (stall) with no limit on stall length.
REQ-023 On the b-th transferred bit of a block: if block counter = t-1, go to DONE; otherwise increment the block counter and go to FETCH.
REQ-024 DONE SHALL assert parity_valid and hold parity stable; parity_ready=1 SHALL return the FSM to IDLE on the next edge, and parity_valid SHALL deassert there.
REQ-025 parity SHALL be driven directly from the accumulator register (no added latency).
REQ-026 start outside IDLE SHALL be ignored, including a start coincident with parity_ready in DONE.
REQ-027 Unstalled latency: t*(b+2) cycles from the start-sampling edge to the last ACCUM edge; parity_valid is high from that edge on.
REQ-028 NUM_INFO_BLOCKS=1 SHALL be legal (single FETCH/LOAD/ACCUM pass).
REQ-029 Counters SHALL be sized clog2 of their range and SHALL never wrap within a codeword.

Reset
REQ-030 Reset SHALL force IDLE and clear accumulator, shift register, and both counters; parity=0, parity_valid=0, info_ready=0, busy=0, g_addr=0.
REQ-031 Reset SHALL take priority over all other inputs in any state, including mid-ACCUM; the partial codeword is discarded.

Configuration
REQ-032 With macro QC_ENC_ABORT_EN defined, the module SHALL add an input abort (1 bit); abort=1 in any non-IDLE state SHALL return the FSM to IDLE next edge with the accumulator cleared and parity_valid=0. Reset still takes priority over abort.
REQ-033 Without QC_ENC_ABORT_EN, the abort port and its logic SHALL be absent; a codeword can be terminated only by reset or by completion.

Verification (b=4, c=2, t=2; g_data for block 1 = 8'hFF; block 1 info bits all 0)
REQ-034 Block 0 g_data=8'h31, block 0 bits 1,0,0,0 -> parity=8'h31, parity_valid high 12 edges after the start-sampling edge.
REQ-035 Block 0 g_data=8'h31, bits 1,1,0,0 -> parity=8'h53.
REQ-036 Same stimulus as REQ-035 with info_valid low for 3 cycles mid-block -> parity=8'h53, latency extended by exactly 3 cycles.
REQ-037 Reset pulsed during block 1 ACCUM -> all outputs equal REQ-030 values; the next start with the REQ-034 stimulus yields 8'h31.
REQ-038 In DONE, hold parity_ready=0 for 5 cycles while pulsing start -> parity_valid and parity stay stable; then parity_ready=1 -> IDLE next edge.
REQ-039 With QC_ENC_ABORT_EN, abort during block 0 ACCUM -> IDLE, parity=0; without the macro, the port does not exist.

Source files
------------

// File: rtl/qc_ldpc_encoder_sraa_param.sv
// Serial QC-LDPC parity encoder built from shift-register-adder-accumulator (SRAA) channels.
// Optional abort input is enabled by defining QC_ENC_ABORT_EN.
module qc_ldpc_encoder_sraa_param #(
  parameter int unsigned CIRC_SIZE       = 88,
  parameter int unsigned NUM_PAR_BLOCKS  = 16,
  parameter int unsigned NUM_INFO_BLOCKS = 32,
  localparam int unsigned ParW  = CIRC_SIZE * NUM_PAR_BLOCKS,
  localparam int unsigned AddrW = (NUM_INFO_BLOCKS > 1) ? $clog2(NUM_INFO_BLOCKS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            info_bit,
  input  logic            info_valid,
  output logic            info_ready,
  output logic [AddrW-1:0] g_addr,
  input  logic [ParW-1:0] g_data,
  output logic [ParW-1:0] parity,
  output logic            parity_valid,
  input  logic            parity_ready,
  output logic            busy
`ifdef QC_ENC_ABORT_EN
  ,
  input  logic            abort
`endif
);

  localparam int unsigned BitW = (CIRC_SIZE > 1) ? $clog2(CIRC_SIZE) : 1;
  localparam logic [BitW-1:0]  LastBit = BitW'(CIRC_SIZE - 1);
  localparam logic [AddrW-1:0] LastBlk = AddrW'(NUM_INFO_BLOCKS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StAccum, StDone} state_e;

  state_e            state_q, state_d;
  logic [ParW-1:0]   acc_q, acc_d;
  logic [ParW-1:0]   sreg_q, sreg_d;
  logic [AddrW-1:0]  blk_q, blk_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [ParW-1:0]   sreg_rot;

  // Each circulant segment rotates toward its MSB: new[k] = old[(k-1) mod b].
  always_comb begin
    sreg_rot = '0;
    for (int j = 0; j < int'(NUM_PAR_BLOCKS); j++) begin
      for (int k = 0; k < int'(CIRC_SIZE); k++) begin
        sreg_rot[j*CIRC_SIZE + k] = sreg_q[j*CIRC_SIZE + ((k + CIRC_SIZE - 1) % CIRC_SIZE)];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sreg_d  = sreg_q;
    blk_d   = blk_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          blk_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        sreg_d  = g_data;
        bit_d   = '0;
        state_d = StAccum;
      end
      StAccum: begin
        if (info_valid) begin
          if (info_bit) acc_d = acc_q ^ sreg_q;
          sreg_d = sreg_rot;
          if (bit_q == LastBit) begin
            // Bit counter is reloaded in LOAD, so it is left at b-1 rather than wrapping.
            if (blk_q == LastBlk) begin
              state_d = StDone;
            end else begin
              blk_d   = blk_q + AddrW'(1);
              state_d = StFetch;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StDone: begin
        if (parity_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef QC_ENC_ABORT_EN
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      acc_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sreg_q  <= '0;
      blk_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sreg_q  <= sreg_d;
      blk_q   <= blk_d;
      bit_q   <= bit_d;
    end
  end

  assign g_addr       = blk_q;
  assign parity       = acc_q;
  assign parity_valid = (state_q == StDone);
  assign info_ready   = (state_q == StAccum);
  assign busy         = (state_q != StIdle);

endmodule
